// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access / writeback stage.
// Takes registered EXE results, performs the data-memory access over a
// req/ack handshake, and drives the writeback pair back to the register file.
// A bounded wait aborts a hung access and raises a sticky bus error.
module mem_wb_stage #(
   parameter int ARQ              = 16,
   parameter int MEMORY_ADDR_SIZE = 13,
   parameter int TIMEOUT          = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic                        wb_enable_in,
   input  logic                        rd_mem_in,
   input  logic                        wr_mem_in,
   input  logic                        mux_mem_in,
   input  logic                        pc_en_in,
   input  logic [ARQ-1:0]              alu_result_in,
   input  logic [ARQ-1:0]              src3_in,
   output logic                        mem_req,
   output logic                        mem_we,
   output logic [MEMORY_ADDR_SIZE-1:0] mem_addr,
   output logic [ARQ-1:0]              mem_wdata,
   input  logic [ARQ-1:0]              mem_rdata,
   input  logic                        mem_ack,
   output logic                        stall,
   output logic [ARQ-1:0]              wb_result,
   output logic                        wr_reg_en,
   output logic                        pc_en_out,
   output logic                        bus_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;

   // Instruction context captured when an access is launched
   logic             wb_en_p1;
   logic             mux_p1;
   logic             pc_en_p1;
   logic             load_p1;
   logic [ARQ-1:0]   alu_p1;

   logic             memop;
   logic             is_load;
   logic             timeout_hit;

   // Writeback source: memory data only for a true load that selects it
   function automatic logic [ARQ-1:0] sel_wb(input logic load, input logic mux,
                                             input logic [ARQ-1:0] rdata,
                                             input logic [ARQ-1:0] alu);
      return (load && mux) ? rdata : alu;
   endfunction

   assign memop       = rd_mem_in | wr_mem_in;
   // A read+write request is executed as a store only
   assign is_load     = rd_mem_in & ~wr_mem_in;
   // An ack in the final cycle takes priority over the abort
   assign timeout_hit = (state == ACCESS) && !mem_ack && (cnt == CNT_W'(TIMEOUT - 1));
   assign stall       = (state == ACCESS) && !mem_ack;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (valid_in && memop)     state_next = ACCESS;
         ACCESS:  if (mem_ack || timeout_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory interface, writeback outputs, captured context and timeout counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wb_result <= '0;
         wr_reg_en <= 1'b0;
         pc_en_out <= 1'b0;
         bus_err   <= 1'b0;
         cnt       <= '0;
         wb_en_p1  <= 1'b0;
         mux_p1    <= 1'b0;
         pc_en_p1  <= 1'b0;
         load_p1   <= 1'b0;
         alu_p1    <= '0;
      end else begin
         case (state)
            IDLE: begin
               wr_reg_en <= 1'b0;
               if (valid_in && memop) begin
                  mem_req   <= 1'b1;
                  mem_we    <= wr_mem_in;
                  mem_addr  <= alu_result_in[MEMORY_ADDR_SIZE-1:0];
                  mem_wdata <= src3_in;
                  wb_en_p1  <= wb_enable_in;
                  mux_p1    <= mux_mem_in;
                  pc_en_p1  <= pc_en_in;
                  load_p1   <= is_load;
                  alu_p1    <= alu_result_in;
                  cnt       <= '0;
               end else if (valid_in) begin
                  wb_result <= alu_result_in;
                  wr_reg_en <= wb_enable_in;
                  pc_en_out <= pc_en_in;
               end
            end
            ACCESS: begin
               wr_reg_en <= 1'b0;
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  wb_result <= sel_wb(load_p1, mux_p1, mem_rdata, alu_p1);
                  wr_reg_en <= wb_en_p1;
                  pc_en_out <= pc_en_p1;
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: wr_reg_en <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vector table plus hand sequences for timeout,
// ack-on-last-cycle and asynchronous reset during an access.
module tb_mem_wb_stage;

   localparam int ARQ = 16;
   localparam int MAS = 13;
   localparam int TO  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           valid_in, wb_enable_in, rd_mem_in, wr_mem_in, mux_mem_in, pc_en_in;
   logic [ARQ-1:0] alu_result_in, src3_in, mem_rdata;
   logic           mem_ack;
   logic           mem_req, mem_we, stall, wr_reg_en, pc_en_out, bus_err;
   logic [MAS-1:0] mem_addr;
   logic [ARQ-1:0] mem_wdata, wb_result;

   int checks = 0;
   int errors = 0;

   mem_wb_stage #(.ARQ(ARQ), .MEMORY_ADDR_SIZE(MAS), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .wb_enable_in(wb_enable_in),
      .rd_mem_in(rd_mem_in), .wr_mem_in(wr_mem_in), .mux_mem_in(mux_mem_in),
      .pc_en_in(pc_en_in), .alu_result_in(alu_result_in), .src3_in(src3_in),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall), .wb_result(wb_result),
      .wr_reg_en(wr_reg_en), .pc_en_out(pc_en_out), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  ctl;     // {valid, wb_enable, rd, wr, mux, pc_en}
      logic [15:0] alu;
      logic [15:0] src3;
      logic [15:0] rdata;
      logic        ack;
      logic        e_stall; // before the edge
      logic        e_req;
      logic        e_we;
      logic [12:0] e_addr;
      logic [15:0] e_wdata;
      logic [15:0] e_wb;
      logic        e_wren;
      logic        e_pce;
      logic        e_err;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic [5:0] ctl, input logic [15:0] alu,
                               input logic [15:0] src3, input logic [15:0] rdata,
                               input logic ack, input logic e_stall, input logic e_req,
                               input logic e_we, input logic [12:0] e_addr,
                               input logic [15:0] e_wdata, input logic [15:0] e_wb,
                               input logic e_wren, input logic e_pce, input logic e_err);
      vec_t v;
      v.ctl = ctl; v.alu = alu; v.src3 = src3; v.rdata = rdata; v.ack = ack;
      v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr;
      v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_wren = e_wren; v.e_pce = e_pce;
      v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [5:0] ctl, input logic [15:0] alu,
                        input logic [15:0] src3, input logic [15:0] rdata, input logic ack);
      {valid_in, wb_enable_in, rd_mem_in, wr_mem_in, mux_mem_in, pc_en_in} = ctl;
      alu_result_in = alu;
      src3_in       = src3;
      mem_rdata     = rdata;
      mem_ack       = ack;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hi;
      logic saw_wren;
      logic saw_nostall;

      // ctl bits: {valid, wb_enable, rd, wr, mux, pc_en}
      //            ctl        alu       src3      rdata     ack st req we addr      wdata     wb        wr pc er
      vecs[0]  = mk(6'b110001, 16'h1234, 16'h0000, 16'h0000, 0,  0, 0,  0, 13'h0000, 16'h0000, 16'h1234, 1, 1, 0); // ALU op
      vecs[1]  = mk(6'b000000, 16'h0000, 16'h0000, 16'h0000, 0,  0, 0,  0, 13'h0000, 16'h0000, 16'h1234, 0, 1, 0); // bubble
      vecs[2]  = mk(6'b111010, 16'hE005, 16'h1111, 16'h0000, 0,  0, 1,  0, 13'h0005, 16'h1111, 16'h1234, 0, 1, 0); // load issue
      vecs[3]  = mk(6'b110001, 16'hFFFF, 16'h2222, 16'h0000, 0,  1, 1,  0, 13'h0005, 16'h1111, 16'h1234, 0, 1, 0); // wait 1
      vecs[4]  = mk(6'b110001, 16'hFFFF, 16'h2222, 16'h0000, 0,  1, 1,  0, 13'h0005, 16'h1111, 16'h1234, 0, 1, 0); // wait 2
      vecs[5]  = mk(6'b000000, 16'h0000, 16'h0000, 16'hBEEF, 1,  0, 0,  0, 13'h0005, 16'h1111, 16'hBEEF, 1, 0, 0); // ack
      vecs[6]  = mk(6'b100100, 16'h0010, 16'hA5A5, 16'h0000, 0,  0, 1,  1, 13'h0010, 16'hA5A5, 16'hBEEF, 0, 0, 0); // store
      vecs[7]  = mk(6'b110001, 16'h5678, 16'h0000, 16'hCCCC, 1,  0, 0,  1, 13'h0010, 16'hA5A5, 16'h0010, 0, 0, 0); // ack
      vecs[8]  = mk(6'b110001, 16'h5678, 16'h0000, 16'h0000, 0,  0, 0,  1, 13'h0010, 16'hA5A5, 16'h5678, 1, 1, 0); // ALU b2b
      vecs[9]  = mk(6'b111111, 16'h0ABC, 16'h0F0F, 16'h0000, 0,  0, 1,  1, 13'h0ABC, 16'h0F0F, 16'h5678, 0, 1, 0); // rd+wr
      vecs[10] = mk(6'b000000, 16'h0000, 16'h0000, 16'hDEAD, 1,  0, 0,  1, 13'h0ABC, 16'h0F0F, 16'h0ABC, 1, 1, 0); // ack
      vecs[11] = mk(6'b000000, 16'h0000, 16'h0000, 16'h9999, 1,  0, 0,  1, 13'h0ABC, 16'h0F0F, 16'h0ABC, 0, 1, 0); // idle ack

      rst = 1'b0;
      drive(6'b000000, 16'h0, 16'h0, 16'h0, 1'b0);
      #12;
      chk("reset_req", mem_req, 0);
      chk("reset_stall", stall, 0);
      chk("reset_wren", wr_reg_en, 0);
      chk("reset_wb", wb_result, 0);
      chk("reset_err", bus_err, 0);
      @(negedge clk);
      rst = 1'b1;
      edge1();

      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].ctl, vecs[i].alu, vecs[i].src3, vecs[i].rdata, vecs[i].ack);
         #1;
         chk($sformatf("v%0d_stall", i), stall, vecs[i].e_stall);
         edge1();
         chk($sformatf("v%0d_req", i), mem_req, vecs[i].e_req);
         chk($sformatf("v%0d_we", i), mem_we, vecs[i].e_we);
         chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].e_addr);
         chk($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_wb", i), wb_result, vecs[i].e_wb);
         chk($sformatf("v%0d_wren", i), wr_reg_en, vecs[i].e_wren);
         chk($sformatf("v%0d_pce", i), pc_en_out, vecs[i].e_pce);
         chk($sformatf("v%0d_err", i), bus_err, vecs[i].e_err);
      end

      // Load that never gets an ack: aborted after TO cycles in ACCESS
      drive(6'b111010, 16'h0020, 16'h0000, 16'h0000, 1'b0);
      edge1();
      drive(6'b000000, 16'h0, 16'h0, 16'h0, 1'b0);
      hi = 0;
      saw_wren = 1'b0;
      saw_nostall = 1'b0;
      for (int i = 0; i < 40 && mem_req; i++) begin
         if (wr_reg_en) saw_wren = 1'b1;
         if (!stall) saw_nostall = 1'b1;
         hi++;
         edge1();
      end
      chk("to_req_cycles", hi, TO);
      chk("to_req_dropped", mem_req, 0);
      chk("to_stall_held", saw_nostall, 0);
      chk("to_no_wren", saw_wren | wr_reg_en, 0);
      chk("to_err", bus_err, 1);
      chk("to_wb_hold", wb_result, 16'h0ABC);
      chk("to_stall_idle", stall, 0);

      // bus_err stays set across a later ALU op
      drive(6'b110001, 16'h4242, 16'h0, 16'h0, 1'b0);
      edge1();
      chk("post_to_wb", wb_result, 16'h4242);
      chk("post_to_wren", wr_reg_en, 1);
      chk("post_to_err", bus_err, 1);

      // Asynchronous reset in the middle of an access
      drive(6'b111010, 16'h0030, 16'h0, 16'h0, 1'b0);
      edge1();
      drive(6'b000000, 16'h0, 16'h0, 16'h0, 1'b0);
      chk("ar_req_before", mem_req, 1);
      chk("ar_stall_before", stall, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("ar_req", mem_req, 0);
      chk("ar_stall", stall, 0);
      chk("ar_wren", wr_reg_en, 0);
      chk("ar_err", bus_err, 0);
      chk("ar_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      edge1();

      // Load acked in its final allowed cycle completes normally
      drive(6'b111011, 16'h0040, 16'h0, 16'h0, 1'b0);
      edge1();
      drive(6'b000000, 16'h0, 16'h0, 16'h0, 1'b0);
      chk("last_req_up", mem_req, 1);
      chk("last_addr", mem_addr, 13'h0040);
      for (int i = 0; i < TO - 1; i++) edge1();
      chk("last_req_still", mem_req, 1);
      drive(6'b000000, 16'h0, 16'h0, 16'h7777, 1'b1);
      #1;
      chk("last_stall_ack", stall, 0);
      edge1();
      drive(6'b000000, 16'h0, 16'h0, 16'h0, 1'b0);
      chk("last_req", mem_req, 0);
      chk("last_wb", wb_result, 16'h7777);
      chk("last_wren", wr_reg_en, 1);
      chk("last_pce", pc_en_out, 1);
      chk("last_err", bus_err, 0);
      edge1();
      chk("last_wren_once", wr_reg_en, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EXE/MEM pipeline register: takes the registered EXE results and control bits and performs the data-memory access through a req/ack handshake.
- Drives the writeback pair `wb_result`/`wr_reg_en` back into the decode-stage register file.
- Raises `stall` to freeze upstream pipeline registers while a memory access is outstanding.
- Includes an access timeout with a sticky error flag.

Parameters:
- ARQ, 16, datapath width in bits.
- MEMORY_ADDR_SIZE, 13, data-memory address width in bits.
- TIMEOUT, 16, max cycles in ACCESS without `mem_ack` before abort; legal range ≥2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_in  in  1  EXE/MEM register holds a live instruction.
- wb_enable_in  in  1  instruction writes the register file.
- rd_mem_in  in  1  load.
- wr_mem_in  in  1  store.
- mux_mem_in  in  1  1 = writeback from memory data, 0 = from ALU result.
- pc_en_in  in  1  pc-enable control, passed through.
- alu_result_in  in  ARQ  ALU result; bits [MEMORY_ADDR_SIZE-1:0] are the memory address.
- src3_in  in  ARQ  store data.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  MEMORY_ADDR_SIZE  access address.
- mem_wdata  out  ARQ  write data.
- mem_rdata  in  ARQ  read data; valid in the `mem_ack` cycle.
- mem_ack  in  1  one-cycle completion strobe.
- stall  out  1  freeze upstream stages.
- wb_result  out  ARQ  writeback data.
- wr_reg_en  out  1  writeback strobe, one cycle per retired instruction.
- pc_en_out  out  1  registered `pc_en_in` of the retired instruction.
- bus_err  out  1  sticky access-timeout flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; timeout counter=0. All registered outputs clear immediately, including a request dropped mid-access:
  - `mem_req`, `mem_we`, `wr_reg_en`, `pc_en_out`, `bus_err` = 0
  - `mem_addr`, `mem_wdata`, `wb_result` = 0
- `stall` is combinational: 1 iff state==ACCESS and `mem_ack`==0. It is 0 in IDLE.
- `memop` = `rd_mem_in` | `wr_mem_in`.
- Both `rd_mem_in` and `wr_mem_in` set: treated as a store only, with no read.
- IDLE, `valid_in`=1, `memop`=0: next edge loads
  - `wb_result` = `alu_result_in`
  - `wr_reg_en` = `wb_enable_in`
  - `pc_en_out` = `pc_en_in`
  
  Latency is 1 cycle. `mux_mem_in` is ignored without a load.
- IDLE, `valid_in`=1, `memop`=1: next edge goes to ACCESS.
  - Registers `mem_req`=1, `mem_we`=`wr_mem_in`, `mem_addr`=`alu_result_in`[MEMORY_ADDR_SIZE-1:0], `mem_wdata`=`src3_in`.
  - Captures `wb_enable_in`, `mux_mem_in`, `pc_en_in`, `alu_result_in` internally.
  - Clears the counter. `wr_reg_en` = 0 that edge.
- IDLE, `valid_in`=0: `wr_reg_en` = 0; all other outputs hold.
- ACCESS: `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are held stable. `valid_in` is ignored. The counter increments each cycle without ack.
- ACCESS with `mem_ack`=1: next edge does the following.
  - `mem_req` = 0; state = IDLE.
  - `wb_result` = `mem_rdata` if the captured op was a load with captured `mux_mem`=1, else the captured ALU result.
  - `wr_reg_en` = captured `wb_enable`; `pc_en_out` = captured `pc_en`.
  
  The ack cycle has `stall`=0, so upstream advances and IDLE accepts the next instruction on the following edge. No bubble is inserted beyond the ack cycle.
- Timeout: if ACCESS sees no ack and the counter == TIMEOUT-1, the next edge does the following.
  - `mem_req` = 0; `bus_err` = 1 (sticky until reset); state = IDLE.
  - `wr_reg_en` = 0, so the instruction is dropped without writeback; `wb_result` holds.
  
  If `mem_ack` arrives in the same cycle as the counter reaching TIMEOUT-1, the ack wins and completes normally.
- `mem_ack` seen while in IDLE: ignored.
- Counter width is $clog2(TIMEOUT). No arithmetic beyond the increment; address truncation drops the upper `alu_result` bits.

Test Plan:
- Reset, then `valid_in`=1, `wb_enable`=1, `memop`=0, `alu_result`=16'h1234 → next cycle `wb_result`=16'h1234, `wr_reg_en`=1 for exactly 1 cycle; `stall` never asserts.
- Load, `alu_result`=16'hE005, `mux_mem`=1, `wb_enable`=1; `mem_ack` 3 cycles after `mem_req` rises with `mem_rdata`=16'hBEEF → `mem_addr`=13'h0005 and `mem_we`=0 held throughout; `stall`=1 for 2 cycles; `wb_result`=16'hBEEF and `wr_reg_en`=1 on the edge after ack.
- Store, `src3`=16'hA5A5, `alu_result`=16'h0010, `wb_enable`=0; immediate ack → `mem_we`=1, `mem_wdata`=16'hA5A5; `wr_reg_en` stays 0; a back-to-back ALU op presented in the ack cycle retires on the next edge.
- Load with no ack, TIMEOUT=16 → `mem_req` drops after 16 cycles in ACCESS; `bus_err`=1 and stays 1 across later ops; no `wr_reg_en`. Repeat with ack in the 16th cycle → normal completion, `bus_err`=0.
- Assert rst=0 mid-ACCESS → `mem_req`, `stall`, `wr_reg_en`, `bus_err` are 0 immediately, without waiting for a clock edge; after release a new load proceeds normally.
- `rd_mem_in`=`wr_mem_in`=1 → `mem_we`=1; `wb_result` takes the ALU result even with `mux_mem`=1.
